// File: rtl/img_pkg.sv
// Shared constants and types for the image frame controller and the
// per-pixel colour datapath it drives.
package img_pkg;

    localparam int PIX_W = 8;

    localparam logic [2:0] MODE_GRAY      = 3'd0;
    localparam logic [2:0] MODE_BRIGHT_UP = 3'd1;
    localparam logic [2:0] MODE_BRIGHT_DN = 3'd2;
    localparam logic [2:0] MODE_INVERT    = 3'd3;
    localparam logic [2:0] MODE_NO_R      = 3'd4;
    localparam logic [2:0] MODE_NO_G      = 3'd5;
    localparam logic [2:0] MODE_NO_B      = 3'd6;
    localparam logic [2:0] MODE_PASS      = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        CAPT  = 3'd3,
        SEND  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/frame_pixel_counter.sv
// Per-frame delivered-pixel counter: clear on frame start, increment on each
// output handshake, and flag when the next increment completes the frame.
module frame_pixel_counter
    import img_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             next_last
);

    localparam int               TOTAL_I = IMG_W * IMG_H;
    localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(TOTAL_I);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_inc_s;

    // Incremented value, clamped at all-ones so an illegal overrun never wraps
    always_comb begin
        count_inc_s = count_r;
        if (count_r == CNT_MAX) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + CNT_ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign count     = count_r;
    assign next_last = (count_inc_s == TOTAL);

endmodule

// File: rtl/image_frame_ctrl.sv
// Frame sequencer: pulls one pixel at a time from the source stream, runs it
// through the external colour datapath and hands the result to the sink.
module image_frame_ctrl
    import img_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       cfg_mode,
    input  logic [7:0]       cfg_val,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [CNT_W-1:0] pix_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_r,
    input  logic [7:0]       in_g,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_r,
    output logic [7:0]       out_g,
    output logic [7:0]       out_b,
    output logic [2:0]       dp_sel_mod,
    output logic [7:0]       dp_val,
    output logic [7:0]       dp_red,
    output logic [7:0]       dp_green,
    output logic [7:0]       dp_blue,
    output logic             dp_done_in,
    output logic             dp_reset,
    input  logic             dp_done_out,
    input  logic [7:0]       dp_red_o,
    input  logic [7:0]       dp_green_o,
    input  logic [7:0]       dp_blue_o
);

    state_t     state_r;
    state_t     state_s;

    logic       dp_reset_r;
    logic       dp_done_in_r;
    logic       out_valid_r;
    logic       frame_done_r;
    logic       err_r;
    logic [2:0] sel_mod_r;
    logic [7:0] val_r;
    pixel_t     pix_in_r;
    pixel_t     pix_out_r;

    logic       start_acc_s;
    logic       in_hs_s;
    logic       res_cap_s;
    logic       dp_miss_s;
    logic       out_hs_s;
    logic       last_s;

    frame_pixel_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_acc_s),
        .inc       (out_hs_s),
        .count     (pix_count),
        .next_last (last_s)
    );

    // Next-state decode; abort overrides every other transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) state_s = FETCH;
                else                 state_s = IDLE;
            end
            FETCH: begin
                if (abort)         state_s = IDLE;
                else if (in_valid) state_s = EXEC;
                else               state_s = FETCH;
            end
            EXEC: begin
                if (abort) state_s = IDLE;
                else       state_s = CAPT;
            end
            CAPT: begin
                if (abort)            state_s = IDLE;
                else if (dp_done_out) state_s = SEND;
                else                  state_s = IDLE;
            end
            SEND: begin
                if (abort)          state_s = IDLE;
                else if (out_ready) state_s = last_s ? DONE : FETCH;
                else                state_s = SEND;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Transition strobes shared by the counter and the data registers
    always_comb begin
        start_acc_s = (state_r == IDLE)  && (state_s == FETCH);
        in_hs_s     = (state_r == FETCH) && (state_s == EXEC);
        res_cap_s   = (state_r == CAPT)  && (state_s == SEND);
        dp_miss_s   = (state_r == CAPT)  && !abort && !dp_done_out;
        out_hs_s    = (state_r == SEND)  && out_ready && !abort;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Control outputs, registered from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_reset_r   <= 1'b1;
            dp_done_in_r <= 1'b0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            dp_reset_r   <= (state_s == IDLE);
            dp_done_in_r <= (state_s == EXEC);
            out_valid_r  <= (state_s == SEND);
            frame_done_r <= (state_s == DONE);
        end
    end

    // Frame configuration and sticky no-answer flag, both renewed per start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_mod_r <= 3'd0;
            val_r     <= 8'd0;
            err_r     <= 1'b0;
        end else if (start_acc_s) begin
            sel_mod_r <= cfg_mode;
            val_r     <= cfg_val;
            err_r     <= 1'b0;
        end else if (dp_miss_s) begin
            err_r     <= 1'b1;
        end else begin
            err_r     <= err_r;
        end
    end

    // Pixel into the datapath and result out of it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_in_r  <= 24'd0;
            pix_out_r <= 24'd0;
        end else begin
            if (in_hs_s) begin
                pix_in_r <= {in_r, in_g, in_b};
            end
            if (res_cap_s) begin
                pix_out_r <= {dp_red_o, dp_green_o, dp_blue_o};
            end
        end
    end

    assign busy       = (state_r != IDLE);
    assign in_ready   = (state_r == FETCH);
    assign frame_done = frame_done_r;
    assign err        = err_r;
    assign out_valid  = out_valid_r;
    assign out_r      = pix_out_r.r;
    assign out_g      = pix_out_r.g;
    assign out_b      = pix_out_r.b;
    assign dp_sel_mod = sel_mod_r;
    assign dp_val     = val_r;
    assign dp_red     = pix_in_r.r;
    assign dp_green   = pix_in_r.g;
    assign dp_blue    = pix_in_r.b;
    assign dp_done_in = dp_done_in_r;
    assign dp_reset   = dp_reset_r;

endmodule
